// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory-controller port between instruction fetch and data MMU.
// One transaction in flight: IDLE -> ISSUE (command pulse) -> WAIT (response/timeout) -> RESP (ready pulse).
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_read_enable,
  input  logic [31:0] if_address,
  output logic [31:0] if_data_out,
  output logic        if_mem_ready,
  input  logic        d_read_enable,
  input  logic        d_write_enable,
  input  logic [31:0] d_address,
  input  logic [31:0] d_data_in,
  output logic [31:0] d_data_out,
  output logic        d_mem_ready,
  input  logic        imc_mem_ready,
  input  logic [31:0] imc_data_out,
  output logic        imc_read_enable,
  output logic        imc_write_enable,
  output logic [31:0] imc_address,
  output logic [31:0] imc_data_in,
  output logic        bus_error,
  output logic        busy
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {PORT_IF = 1'b0, PORT_D = 1'b1} port_t;

  state_t        state;
  port_t         last_grant;
  port_t         grant;
  logic          write_op;
  logic [CW-1:0] count;

  logic if_req;
  logic d_req;
  logic pick_d;
  logic timed_out;

  assign if_req = if_read_enable;
  assign d_req  = d_read_enable | d_write_enable;
  // Under contention the port that did not win last time is served.
  assign pick_d = (if_req && d_req) ? (last_grant == PORT_IF) : d_req;
  assign timed_out = (TIMEOUT_CYCLES != 0) && (count == LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      last_grant       <= PORT_D;
      grant            <= PORT_IF;
      write_op         <= 1'b0;
      count            <= '0;
      if_data_out      <= '0;
      if_mem_ready     <= 1'b0;
      d_data_out       <= '0;
      d_mem_ready      <= 1'b0;
      imc_read_enable  <= 1'b0;
      imc_write_enable <= 1'b0;
      imc_address      <= '0;
      imc_data_in      <= '0;
      bus_error        <= 1'b0;
      busy             <= 1'b0;
    end else begin
      if_mem_ready     <= 1'b0;
      d_mem_ready      <= 1'b0;
      bus_error        <= 1'b0;
      imc_read_enable  <= 1'b0;
      imc_write_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            grant            <= pick_d ? PORT_D : PORT_IF;
            write_op         <= pick_d && d_write_enable;
            imc_address      <= pick_d ? d_address : if_address;
            imc_data_in      <= d_data_in;
            imc_read_enable  <= !(pick_d && d_write_enable);
            imc_write_enable <= pick_d && d_write_enable;
            busy             <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          count <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Ready and error are raised on entry to RESP so they are registered pulses there.
          if (imc_mem_ready || timed_out) begin
            if (!write_op) begin
              if (grant == PORT_IF) if_data_out <= imc_mem_ready ? imc_data_out : '0;
              else                  d_data_out  <= imc_mem_ready ? imc_data_out : '0;
            end
            if_mem_ready <= (grant == PORT_IF);
            d_mem_ready  <= (grant == PORT_D);
            bus_error    <= !imc_mem_ready;
            state        <= RESP;
          end else if (count != {CW{1'b1}}) begin
            count <= count + CW'(1);
          end
        end
        RESP: begin
          last_grant <= grant;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
